stb_window_counter: RTL and testbench

// Multi-channel stochastic-to-binary converter: counts 1s per channel over a window of 2^LEN_W valid bitstream samples.
// - Each channel is converted to a unipolar count or a bipolar signed value.
// - Successor to the free-running StB counter: adds a bounded window, start/done/abort handshake,

---
 rtl/stb_window_counter.sv | 85 ++++++++
 tb/tb_stb_window_counter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/stb_window_counter.sv
// stb_window_counter: multi-channel stochastic-to-binary converter over a 2^LEN_W valid-sample window
// with start/abort handshake and unipolar or bipolar result per channel.
module stb_window_counter #(
    parameter int CH    = 4,
    parameter int LEN_W = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       mode_bipolar,
    input  logic                       bit_valid,
    input  logic [CH-1:0]              bit_in,
    output logic                       busy,
    output logic                       done,
    output logic                       result_valid,
    output logic [CH*(LEN_W+2)-1:0]    result
);
    localparam int RW = LEN_W + 2;
    localparam logic [RW-1:0]  NSAMP = {2'b01, {LEN_W{1'b0}}};
    localparam logic [LEN_W:0] LAST  = {1'b0, {LEN_W{1'b1}}};
    localparam logic [LEN_W:0] ONE   = (LEN_W+1)'(1);

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t                  state_q;
    logic [LEN_W:0]          cnt_q;
    logic [CH-1:0][LEN_W:0]  acc_q, ones_d;
    logic [CH-1:0][RW-1:0]   res_q, res_d;
    logic                    bip_q, busy_q, done_q, rv_q;

    // Final value includes the bit sampled on the closing edge.
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            ones_d[c] = acc_q[c] + (LEN_W+1)'(bit_in[c]);
            res_d[c]  = bip_q ? {ones_d[c], 1'b0} - NSAMP : {1'b0, ones_d[c]};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            bip_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rv_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == COUNT) begin
                if (abort) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    acc_q   <= '0;
                    rv_q    <= 1'b0;
                end else if (bit_valid) begin
                    cnt_q <= cnt_q + ONE;
                    acc_q <= ones_d;
                    if (cnt_q == LAST) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        rv_q    <= 1'b1;
                        res_q   <= res_d;
                    end
                end
            end else if (start) begin
                state_q <= COUNT;
                busy_q  <= 1'b1;
                cnt_q   <= '0;
                acc_q   <= '0;
                bip_q   <= mode_bipolar;
                rv_q    <= 1'b0;
            end
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign result_valid = rv_q;
    assign result       = res_q;
endmodule

// File: tb/tb_stb_window_counter.sv
// tb_stb_window_counter: directed windows with a result scoreboard drained on each done pulse.
module tb_stb_window_counter;
    logic        clk = 1'b0, resetn = 1'b0, start = 1'b0, abort = 1'b0;
    logic        mode_bipolar = 1'b0, bit_valid = 1'b0;
    logic [1:0]  bit_in = 2'b00;
    logic        busy, done, result_valid;
    logic [11:0] result;

    stb_window_counter #(.CH(2), .LEN_W(4)) dut (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort),
        .mode_bipolar(mode_bipolar), .bit_valid(bit_valid), .bit_in(bit_in),
        .busy(busy), .done(done), .result_valid(result_valid), .result(result)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0, n_err = 0;
    logic [11:0] exp_q[$];
    logic [11:0] last_res = '0;
    logic [11:0] mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resetn && done) begin
            if (exp_q.size() == 0) chk("unexpected_done", {31'd0, done}, 32'd0);
            else begin
                mon_e = exp_q.pop_front();
                chk("result", {20'd0, result}, {20'd0, mon_e});
                chk("result_valid_at_done", {31'd0, result_valid}, 32'd1);
                chk("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    // abort_at = -2 asserts abort together with the opening start (start must win).
    task automatic window(input logic bip, input logic [15:0] p0, input logic [15:0] p1,
                          input bit gap, input int start_at, input int abort_at,
                          input bit both, input logic [11:0] expv);
        start = 1'b1; mode_bipolar = bip; abort = (abort_at == -2); bit_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0; mode_bipolar = ~bip;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("rv_cleared", {31'd0, result_valid}, 32'd0);
        chk("result_held", {20'd0, result}, {20'd0, last_res});
        if (abort_at < 0) exp_q.push_back(expv);
        for (int i = 0; i < 16; i++) begin
            if (gap) begin
                bit_valid = 1'b0; bit_in = 2'b11;
                @(posedge clk); #1;
            end
            bit_valid = 1'b1; bit_in = {p1[i], p0[i]};
            start = (i == start_at) || (both && i == abort_at);
            abort = (i == abort_at);
            if (i == 15) chk("no_early_done", {31'd0, done}, 32'd0);
            @(posedge clk); #1;
            start = 1'b0; abort = 1'b0; bit_valid = 1'b0; bit_in = 2'b10;
            if (i == abort_at) begin
                chk("abort_busy", {31'd0, busy}, 32'd0);
                chk("abort_rv", {31'd0, result_valid}, 32'd0);
                chk("abort_result", {20'd0, result}, {20'd0, last_res});
                @(posedge clk); #1;
                chk("abort_no_done", {31'd0, done}, 32'd0);
                return;
            end
        end
        chk("done_latency", {31'd0, done}, 32'd1);
        last_res = expv;
        if (start_at == 15) begin
            @(posedge clk); #1;
            chk("late_start_ignored", {31'd0, busy}, 32'd0);
            chk("done_one_cycle", {31'd0, done}, 32'd0);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rv", {31'd0, result_valid}, 32'd0);
        chk("rst_result", {20'd0, result}, 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;
        window(1'b0, 16'hFFFF, 16'h1111, 1'b0, -1, -1, 1'b0, {6'd4, 6'd16});
        window(1'b1, 16'hFFFF, 16'h0000, 1'b0, 5, -1, 1'b0, {6'h30, 6'h10});
        window(1'b1, 16'hAAAA, 16'hAAAA, 1'b0, 15, -1, 1'b0, {6'h00, 6'h00});
        window(1'b0, 16'hFFFF, 16'h0000, 1'b1, -1, -1, 1'b0, {6'd0, 6'd16});
        window(1'b0, 16'hFFFF, 16'hFFFF, 1'b0, -1, 9, 1'b0, 12'h000);
        window(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, -1, 4, 1'b1, 12'h000);
        window(1'b1, 16'h0007, 16'h7FFF, 1'b0, -1, -2, 1'b0, {6'h0E, 6'h36});
        start = 1'b1; mode_bipolar = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; bit_valid = 1'b1; bit_in = 2'b11;
        repeat (5) @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_rv", {31'd0, result_valid}, 32'd0);
        chk("midrst_result", {20'd0, result}, 32'd0);
        last_res = '0;
        bit_valid = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        window(1'b0, 16'h8001, 16'h0F00, 1'b0, -1, -1, 1'b0, {6'd4, 6'd2});
        window(1'b1, 16'h0000, 16'hFFFF, 1'b0, -1, -1, 1'b0, {6'h10, 6'h30});
        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
